// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI slave transmit FIFO.
// Pointer widths are derived from the depth through clog2.
package spi_slave_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    localparam int FIFO_DEPTH_C = 16;

    // Extra MSB is the wrap bit that separates full from empty.
    typedef logic [clog2(FIFO_DEPTH_C):0] fifo_ptr_t;

endpackage

// File: rtl/spi_fifo_ram.sv
// Simple dual-port RAM with a synchronous write port and a registered read port.
// The read register doubles as the FIFO data output.
module spi_fifo_ram
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH_G = 8,
    parameter int DEPTH_G = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [clog2(DEPTH_G)-1:0]   waddr,
    input  logic [DATA_WIDTH_G-1:0]     wdata,
    input  logic                        re,
    input  logic [clog2(DEPTH_G)-1:0]   raddr,
    output logic [DATA_WIDTH_G-1:0]     rdata
);

    logic [DATA_WIDTH_G-1:0] mem [DEPTH_G];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read-first: a read and write to the same slot returns the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/spi_slave_tx_fifo.sv
// Host-side transmit FIFO feeding spi_slave's request/data port group.
// Pointers, registered flags, fill level and event pulses live here.
module spi_slave_tx_fifo
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH_G = 8,
    parameter int DEPTH_G = 16,
    parameter int ALMOST_FULL_G = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      wr_en,
    input  logic [DATA_WIDTH_G-1:0]   wr_data,
    output logic                      full,
    output logic                      almost_full,
    output logic                      overflow,
    input  logic                      fifo_req_data,
    output logic [DATA_WIDTH_G-1:0]   fifo_din,
    output logic                      fifo_din_valid,
    output logic                      fifo_empty,
    output logic                      underflow,
    output logic [clog2(DEPTH_G):0]   used
);

    localparam int AW = clog2(DEPTH_G);
    localparam logic [AW:0] AF_C = (AW+1)'(ALMOST_FULL_G);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_nxt;
    logic [AW:0] rd_nxt;
    logic [AW:0] used_nxt;
    logic        rd_ok;
    logic        wr_ok;
    logic        full_nxt;

    // A read frees a slot in the same cycle, so a write to a full FIFO
    // is accepted when paired with a valid read.
    always_comb begin
        rd_ok    = fifo_req_data && !fifo_empty && !flush;
        wr_ok    = wr_en && !flush && (!full || rd_ok);
        wr_nxt   = flush ? '0 : wr_ptr + (AW+1)'(wr_ok);
        rd_nxt   = flush ? '0 : rd_ptr + (AW+1)'(rd_ok);
        used_nxt = wr_nxt - rd_nxt;
        full_nxt = (wr_nxt[AW] != rd_nxt[AW]) &&
                   (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            used           <= '0;
            full           <= 1'b0;
            almost_full    <= 1'b0;
            fifo_empty     <= 1'b1;
            fifo_din_valid <= 1'b0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            wr_ptr         <= wr_nxt;
            rd_ptr         <= rd_nxt;
            used           <= used_nxt;
            full           <= full_nxt;
            almost_full    <= used_nxt >= AF_C;
            fifo_empty     <= wr_nxt == rd_nxt;
            fifo_din_valid <= rd_ok;
            overflow       <= wr_en && !flush && full && !rd_ok;
            underflow      <= fifo_req_data && !flush && fifo_empty;
        end
    end

    spi_fifo_ram #(
        .DATA_WIDTH_G (DATA_WIDTH_G),
        .DEPTH_G      (DEPTH_G)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .re    (rd_ok),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (fifo_din)
    );

endmodule

// File: tb/tb_spi_slave_tx_fifo.sv
// Directed bench for spi_slave_tx_fifo with DEPTH_G=16, ALMOST_FULL_G=12.
// Each step drives one clock and checks the registered outputs just after it.
module tb_spi_slave_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic       fifo_req_data;
    logic [7:0] fifo_din;
    logic       fifo_din_valid;
    logic       fifo_empty;
    logic       underflow;
    logic [4:0] used;

    int errors = 0;
    int checks = 0;
    logic [7:0] q[$];
    logic [7:0] d;
    logic [7:0] e;

    spi_slave_tx_fifo #(
        .DATA_WIDTH_G  (8),
        .DEPTH_G       (16),
        .ALMOST_FULL_G (12)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .full           (full),
        .almost_full    (almost_full),
        .overflow       (overflow),
        .fifo_req_data  (fifo_req_data),
        .fifo_din       (fifo_din),
        .fifo_din_valid (fifo_din_valid),
        .fifo_empty     (fifo_empty),
        .underflow      (underflow),
        .used           (used)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic [7:0] wd,
                       input logic r, input logic f);
        wr_en = w;
        wr_data = wd;
        fifo_req_data = r;
        flush = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        wr_en = 1'b0;
        wr_data = 8'h00;
        fifo_req_data = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_used", 32'(used), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_valid", 32'(fifo_din_valid), 0);
        chk("rst_din", 32'(fifo_din), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // ordering and latency
        cyc(1, 8'h11, 0, 0);
        chk("wr1_used", 32'(used), 1);
        chk("wr1_empty", 32'(fifo_empty), 0);
        cyc(1, 8'h22, 0, 0);
        cyc(1, 8'h33, 0, 0);
        chk("wr3_used", 32'(used), 3);
        cyc(0, 8'h00, 1, 0);
        chk("rd1_valid", 32'(fifo_din_valid), 1);
        chk("rd1_din", 32'(fifo_din), 32'h11);
        cyc(0, 8'h00, 1, 0);
        chk("rd2_valid", 32'(fifo_din_valid), 1);
        chk("rd2_din", 32'(fifo_din), 32'h22);
        cyc(0, 8'h00, 1, 0);
        chk("rd3_valid", 32'(fifo_din_valid), 1);
        chk("rd3_din", 32'(fifo_din), 32'h33);
        chk("rd3_empty", 32'(fifo_empty), 1);
        chk("rd3_used", 32'(used), 0);
        cyc(0, 8'h00, 0, 0);
        chk("idle_valid", 32'(fifo_din_valid), 0);
        chk("idle_hold", 32'(fifo_din), 32'h33);

        // fill, almost_full, full, overflow
        for (int i = 0; i < 16; i++) begin
            cyc(1, 8'(i), 0, 0);
            chk("fill_used", 32'(used), 32'(i + 1));
            chk("fill_af", 32'(almost_full), 32'(i + 1 >= 12));
            chk("fill_full", 32'(full), 32'(i + 1 == 16));
        end
        cyc(1, 8'hAA, 0, 0);
        chk("ovf_pulse", 32'(overflow), 1);
        chk("ovf_used", 32'(used), 16);
        cyc(0, 8'h00, 0, 0);
        chk("ovf_clear", 32'(overflow), 0);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 8'h00, 1, 0);
            chk("drain_valid", 32'(fifo_din_valid), 1);
            chk("drain_din", 32'(fifo_din), 32'(i));
        end
        chk("drain_empty", 32'(fifo_empty), 1);
        chk("drain_af", 32'(almost_full), 0);
        cyc(0, 8'h00, 1, 0);
        chk("no_aa_valid", 32'(fifo_din_valid), 0);
        chk("no_aa_unf", 32'(underflow), 1);
        cyc(0, 8'h00, 0, 0);

        // full with simultaneous read and write
        for (int i = 0; i < 16; i++) cyc(1, 8'(8'h80 + i), 0, 0);
        chk("sim_pre_full", 32'(full), 1);
        cyc(1, 8'h55, 1, 0);
        chk("sim_ovf", 32'(overflow), 0);
        chk("sim_used", 32'(used), 16);
        chk("sim_full", 32'(full), 1);
        chk("sim_din", 32'(fifo_din), 32'h80);
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 8'h00, 1, 0);
            e = (i == 16) ? 8'h55 : 8'(8'h80 + i);
            chk("sim_drain", 32'(fifo_din), 32'(e));
        end
        chk("sim_empty", 32'(fifo_empty), 1);

        // underflow with simultaneous write
        cyc(1, 8'h77, 1, 0);
        chk("unf_pulse", 32'(underflow), 1);
        chk("unf_valid", 32'(fifo_din_valid), 0);
        chk("unf_used", 32'(used), 1);
        cyc(0, 8'h00, 1, 0);
        chk("unf_clear", 32'(underflow), 0);
        chk("unf_valid2", 32'(fifo_din_valid), 1);
        chk("unf_din", 32'(fifo_din), 32'h77);

        // steady read/write across pointer wrap
        cyc(1, 8'hC0, 0, 0);
        q.push_back(8'hC0);
        for (int k = 0; k < 40; k++) begin
            d = 8'(k * 7 + 3);
            cyc(1, d, 1, 0);
            q.push_back(d);
            e = q.pop_front();
            chk("wrap_valid", 32'(fifo_din_valid), 1);
            chk("wrap_din", 32'(fifo_din), 32'(e));
            chk("wrap_used", 32'(used), 1);
        end
        cyc(0, 8'h00, 1, 0);
        e = q.pop_front();
        chk("wrap_last", 32'(fifo_din), 32'(e));

        // flush overrides write and read
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'hD0 + i), 0, 0);
        chk("pre_flush_used", 32'(used), 5);
        cyc(1, 8'hEE, 1, 1);
        chk("flush_used", 32'(used), 0);
        chk("flush_empty", 32'(fifo_empty), 1);
        chk("flush_full", 32'(full), 0);
        chk("flush_valid", 32'(fifo_din_valid), 0);
        chk("flush_ovf", 32'(overflow), 0);
        chk("flush_unf", 32'(underflow), 0);
        cyc(0, 8'h00, 1, 0);
        chk("post_flush_unf", 32'(underflow), 1);
        chk("post_flush_valid", 32'(fifo_din_valid), 0);

        // asynchronous reset mid-transfer
        cyc(1, 8'h3C, 0, 0);
        cyc(1, 8'h4D, 0, 0);
        cyc(0, 8'h00, 1, 0);
        chk("pre_rst_valid", 32'(fifo_din_valid), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(fifo_din_valid), 0);
        chk("arst_din", 32'(fifo_din), 0);
        chk("arst_used", 32'(used), 0);
        chk("arst_empty", 32'(fifo_empty), 1);
        fifo_req_data = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 8'h00, 0, 0);
        chk("after_rst_empty", 32'(fifo_empty), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
